sliding_window_buffer: RTL and testbench
========================================

SLIDING_WINDOW_BUFFER -- requirements
Module: sliding_window_buffer

Interface
REQ-001 SHALL have parameter DATA_W, default 8, pixel width in bits.
REQ-002 SHALL have parameter IMG_WIDTH, default 8, pixels per row (>= K).
REQ-003 SHALL have parameter IMG_HEIGHT, default 8, rows per frame (>= K).
REQ-004 SHALL have parameter K, default 3, window edge (odd, 3..7).
REQ-005 SHALL have parameter STRIDE, default 1, window step in rows and cols (1..K).
REQ-006 SHALL have port clk, input, 1, single clock; all logic on rising edge.
REQ-007 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-008 SHALL have port pixel_valid, input, 1, pixel_in/pixel_sof valid.
REQ-009 SHALL have port pixel_ready, output, 1, block can accept a pixel.
REQ-010 SHALL have port pixel_in, input, DATA_W, raster-order pixel.
REQ-011 SHALL have port pixel_sof, input, 1, pixel is row 0 col 0 of a new frame.
REQ-012 SHALL have port window_valid, output, 1, window_out holds an unconsumed window.
REQ-013 SHALL have port window_ready, input, 1, consumer accepts the window.
REQ-014 SHALL have port window_out, output, K*K*DATA_W, window pixels.
REQ-015 SHALL have port window_row, output, 16, frame row of the window's bottom-right pixel.
REQ-016 SHALL have port window_col, output, 16, frame col of the window's bottom-right pixel.
REQ-017 SHALL have port frame_done, output, 1, one-cycle pulse after the last pixel of a frame.

Function
REQ-018 SHALL accept a pixel only in a cycle with pixel_valid=1 and pixel_ready=1 (a "transfer").
REQ-019 SHALL drive pixel_ready = !window_valid || window_ready (combinational; single output register, no skid).
REQ-020 SHALL hold K-1 previous rows in line storage plus the last K-1 pixels of the current row.
REQ-021 SHALL track col (0..IMG_WIDTH-1) and row (0..IMG_HEIGHT-1) of the next expected pixel; col wraps to 0 with row+1; on col=IMG_WIDTH-1 and row=IMG_HEIGHT-1 both wrap to 0.
REQ-022 SHALL, on a transfer with pixel_sof=1, treat that pixel as row 0 col 0 regardless of counter state and continue counting from there.
REQ-023 SHALL produce a window on a transfer at (r,c) iff r>=K-1, c>=K-1, (r-(K-1)) mod STRIDE=0 and (c-(K-1)) mod STRIDE=0.
REQ-024 SHALL contain in the window the pixels of rows r-K+1..r and cols c-K+1..c, top-left pixel in the MSBs, row-major, bottom-right (current pixel) in the LSBs.
REQ-025 SHALL register the window: window_valid, window_out, window_row=r, window_col=c update on the clock edge of the producing transfer (latency 1 cycle).
REQ-026 SHALL keep window_valid, window_out, window_row, window_col stable while window_valid=1 and window_ready=0.
REQ-027 SHALL clear window_valid on a cycle with window_ready=1 and no new window produced; a simultaneous consume and produce loads the new window with window_valid staying 1.
REQ-028 SHALL pulse frame_done for exactly one cycle on the edge of the transfer at (IMG_HEIGHT-1, IMG_WIDTH-1), independent of window_ready.
REQ-029 SHALL never use data from a previous frame in a window: row gating per REQ-023 after sof or wrap, line storage not cleared.
REQ-030 SHALL ignore pixel_in/pixel_sof when no transfer occurs; counters and storage unchanged.

Reset
REQ-031 SHALL, while rst=1, force window_valid=0, window_out=0, window_row=0, window_col=0, frame_done=0, row=0, col=0, retained pixels of current row=0.
REQ-032 SHALL, on rst asserted mid-frame, discard the partial frame; the next transfer is row 0 col 0; line storage contents are not reset.

Verification
REQ-033 8x8, K=3, STRIDE=1, pixel=row*8+col, window_ready=1 -> first window after pixel 18: window_out = {0,1,2,8,9,10,16,17,18}, window_row=2, window_col=2; 36 windows; frame_done after pixel 63.
REQ-034 Same frame, STRIDE=2 -> 9 windows at (r,c) in {2,4,6}x{2,4,6}; last window bottom-right=54.
REQ-035 window_ready=0 after first window -> pixel_ready=0 next cycle, window_out held {0,1,...,18} for 10 cycles; release -> next window {1,2,3,9,10,11,17,18,19}.
REQ-036 pixel_sof=1 at pixel 30 of frame A, then new frame B=100+index -> no window until B row 2 col 2; first B window contains only B values (bottom-right 118).
REQ-037 rst pulsed after pixel 20 -> all outputs 0; restarted 8x8 frame yields 36 windows, first at pixel 18.
REQ-038 K=5, 8x8, STRIDE=1 -> first window after pixel 36 with top-left 0, bottom-right 36; 16 windows per frame.

Source files
------------

// File: rtl/sliding_window_buffer.sv
// Streaming KxK window generator over a raster pixel stream.
// K-1 line rows plus a K-1 column shift register feed a single registered window output.
module sliding_window_buffer #(
  parameter int DATA_W     = 8,
  parameter int IMG_WIDTH  = 8,
  parameter int IMG_HEIGHT = 8,
  parameter int K          = 3,
  parameter int STRIDE     = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    pixel_valid,
  output logic                    pixel_ready,
  input  logic [DATA_W-1:0]       pixel_in,
  input  logic                    pixel_sof,
  output logic                    window_valid,
  input  logic                    window_ready,
  output logic [K*K*DATA_W-1:0]   window_out,
  output logic [15:0]             window_row,
  output logic [15:0]             window_col,
  output logic                    frame_done
);

  localparam int          CIW      = $clog2(IMG_WIDTH);
  localparam int          WW       = K * K * DATA_W;
  localparam logic [15:0] LAST_COL = 16'(IMG_WIDTH - 1);
  localparam logic [15:0] LAST_ROW = 16'(IMG_HEIGHT - 1);
  localparam logic [15:0] KM1      = 16'(K - 1);
  localparam logic [15:0] STR      = 16'(STRIDE);

  // line_q[0] is the row just above the current one, line_q[K-2] the oldest.
  logic [DATA_W-1:0] line_q     [K-1][IMG_WIDTH];
  logic [DATA_W-1:0] line_col_d [K-1];

  // cols_q[0] is the oldest retained column; index [m][i] has row i = 0 at the top.
  logic [DATA_W-1:0] cols_q  [K-1][K];
  logic [DATA_W-1:0] cols_d  [K-1][K];
  logic [DATA_W-1:0] new_col [K];

  logic [15:0]    col_q, col_d, row_q, row_d;
  logic [15:0]    cur_col, cur_row;
  logic [CIW-1:0] col_idx;
  logic           xfer, produce, at_last;

  logic           window_valid_q, window_valid_d;
  logic [WW-1:0]  window_out_q, window_out_d;
  logic [15:0]    window_row_q, window_row_d;
  logic [15:0]    window_col_q, window_col_d;
  logic           frame_done_q, frame_done_d;

  assign pixel_ready  = !window_valid_q || window_ready;
  assign window_valid = window_valid_q;
  assign window_out   = window_out_q;
  assign window_row   = window_row_q;
  assign window_col   = window_col_q;
  assign frame_done   = frame_done_q;

  always_comb begin
    xfer    = pixel_valid && pixel_ready;
    cur_col = pixel_sof ? '0 : col_q;
    cur_row = pixel_sof ? '0 : row_q;
    col_idx = cur_col[CIW-1:0];
    at_last = (cur_col == LAST_COL) && (cur_row == LAST_ROW);

    // Read the line rows before this transfer overwrites the column.
    for (int unsigned i = 0; i < K - 1; i++) begin
      new_col[i] = line_q[K-2-i][col_idx];
    end
    new_col[K-1] = pixel_in;

    line_col_d[0] = pixel_in;
    for (int unsigned j = 1; j < K - 1; j++) begin
      line_col_d[j] = line_q[j-1][col_idx];
    end

    produce = xfer && (cur_row >= KM1) && (cur_col >= KM1) &&
              (((cur_row - KM1) % STR) == '0) && (((cur_col - KM1) % STR) == '0);

    col_d = col_q;
    row_d = row_q;
    if (xfer) begin
      if (cur_col == LAST_COL) begin
        col_d = '0;
        row_d = (cur_row == LAST_ROW) ? '0 : cur_row + 16'd1;
      end else begin
        col_d = cur_col + 16'd1;
        row_d = cur_row;
      end
    end

    cols_d = cols_q;
    if (xfer) begin
      for (int unsigned m = 0; m < K - 2; m++) begin
        cols_d[m] = cols_q[m+1];
      end
      cols_d[K-2] = new_col;
    end

    window_valid_d = window_valid_q;
    window_out_d   = window_out_q;
    window_row_d   = window_row_q;
    window_col_d   = window_col_q;
    if (produce) begin
      window_valid_d = 1'b1;
      window_row_d   = cur_row;
      window_col_d   = cur_col;
      for (int unsigned i = 0; i < K; i++) begin
        for (int unsigned j = 0; j < K; j++) begin
          window_out_d[(K*K-1-(i*K+j))*DATA_W +: DATA_W] =
            (j == K - 1) ? new_col[i] : cols_q[j][i];
        end
      end
    end else if (window_ready) begin
      window_valid_d = 1'b0;
    end

    frame_done_d = xfer && at_last;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_q          <= '0;
      row_q          <= '0;
      cols_q         <= '{default: '0};
      window_valid_q <= 1'b0;
      window_out_q   <= '0;
      window_row_q   <= '0;
      window_col_q   <= '0;
      frame_done_q   <= 1'b0;
    end else begin
      col_q          <= col_d;
      row_q          <= row_d;
      cols_q         <= cols_d;
      window_valid_q <= window_valid_d;
      window_out_q   <= window_out_d;
      window_row_q   <= window_row_d;
      window_col_q   <= window_col_d;
      frame_done_q   <= frame_done_d;
    end
  end

  // Line storage is deliberately not reset; row gating keeps stale rows out of windows.
  always_ff @(posedge clk) begin
    if (xfer) begin
      for (int unsigned j = 0; j < K - 1; j++) begin
        line_q[j][col_idx] <= line_col_d[j];
      end
    end
  end

endmodule

// File: tb/tb_sliding_window_buffer.sv
// Directed bench for sliding_window_buffer: K=3/STRIDE=1 main instance with
// K=3/STRIDE=2 and K=5/STRIDE=1 companions fed the first frame.
module tb_sliding_window_buffer;

  logic         clk = 1'b0;
  logic         rst;
  logic         pv, pv_aux, psof, wr;
  logic [7:0]   pin;

  logic         pr, wv, fd;
  logic [71:0]  wo;
  logic [15:0]  wrow, wcol;

  logic         pr_s2, wv_s2, fd_s2;
  logic [71:0]  wo_s2;
  logic [15:0]  wrow_s2, wcol_s2;

  logic         pr_k5, wv_k5, fd_k5;
  logic [199:0] wo_k5;
  logic [15:0]  wrow_k5, wcol_k5;

  int total = 0;
  int bad   = 0;

  int cnt_m = 0, cnt_s2 = 0, cnt_k5 = 0, fd_cnt = 0;
  int last_s2_row = 0, last_s2_col = 0, last_s2_br = 0;

  always #5 clk = ~clk;

  sliding_window_buffer #(.DATA_W(8), .IMG_WIDTH(8), .IMG_HEIGHT(8), .K(3), .STRIDE(1)) dut (
    .clk(clk), .rst(rst), .pixel_valid(pv), .pixel_ready(pr), .pixel_in(pin),
    .pixel_sof(psof), .window_valid(wv), .window_ready(wr), .window_out(wo),
    .window_row(wrow), .window_col(wcol), .frame_done(fd));

  sliding_window_buffer #(.DATA_W(8), .IMG_WIDTH(8), .IMG_HEIGHT(8), .K(3), .STRIDE(2)) dut_s2 (
    .clk(clk), .rst(rst), .pixel_valid(pv_aux), .pixel_ready(pr_s2), .pixel_in(pin),
    .pixel_sof(psof), .window_valid(wv_s2), .window_ready(1'b1), .window_out(wo_s2),
    .window_row(wrow_s2), .window_col(wcol_s2), .frame_done(fd_s2));

  sliding_window_buffer #(.DATA_W(8), .IMG_WIDTH(8), .IMG_HEIGHT(8), .K(5), .STRIDE(1)) dut_k5 (
    .clk(clk), .rst(rst), .pixel_valid(pv_aux), .pixel_ready(pr_k5), .pixel_in(pin),
    .pixel_sof(psof), .window_valid(wv_k5), .window_ready(1'b1), .window_out(wo_k5),
    .window_row(wrow_k5), .window_col(wcol_k5), .frame_done(fd_k5));

  // Window consumption and frame_done tallies, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst) begin
      if (wv && wr) cnt_m++;
      if (wv_s2) begin
        cnt_s2++;
        last_s2_row = int'(wrow_s2);
        last_s2_col = int'(wcol_s2);
        last_s2_br  = int'(wo_s2[7:0]);
      end
      if (wv_k5) cnt_k5++;
      if (fd) fd_cnt++;
    end
  end

  // Expected window for an 8-wide frame whose pixel value is base + row*8 + col.
  function automatic logic [199:0] mkwin(input int k, input int r, input int c, input int base);
    logic [199:0] w;
    w = '0;
    for (int i = 0; i < k; i++) begin
      for (int j = 0; j < k; j++) begin
        w[(k*k-1-(i*k+j))*8 +: 8] = 8'(base + (r-k+1+i)*8 + (c-k+1+j));
      end
    end
    return w;
  endfunction

  task automatic chk(input string tag, input logic [199:0] got, input logic [199:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Offer one pixel; returns at posedge+1 of the transfer edge.
  task automatic push(input int v, input logic s, input logic aux);
    int n;
    pin = 8'(v); psof = s; pv = 1'b1; pv_aux = aux; n = 0;
    @(negedge clk);
    while (!pr && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!pr) chk("ready_timeout", {199'b0, pr}, 200'd1);
    @(posedge clk); #1;
    pv = 1'b0; pv_aux = 1'b0; psof = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int m0, f0, early, held_bad;
    rst = 1'b1; pv = 1'b0; pv_aux = 1'b0; psof = 1'b0; pin = '0; wr = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", {199'b0, wv}, 200'd0);
    chk("rst_out", {128'b0, wo}, 200'd0);
    chk("rst_row", {184'b0, wrow}, 200'd0);
    chk("rst_col", {184'b0, wcol}, 200'd0);
    chk("rst_fdone", {199'b0, fd}, 200'd0);
    chk("rst_ready", {199'b0, pr}, 200'd1);
    rst = 1'b0;
    @(posedge clk); #1;

    // Frame 1: all three instances, consumer always ready.
    m0 = cnt_m; f0 = fd_cnt;
    for (int idx = 0; idx < 64; idx++) begin
      push(idx, idx == 0, 1'b1);
      if (idx == 17) chk("no_win_before_18", {199'b0, wv}, 200'd0);
      if (idx == 18) begin
        chk("first_valid", {199'b0, wv}, 200'd1);
        chk("first_out", {128'b0, wo}, mkwin(3, 2, 2, 0));
        chk("first_row", {184'b0, wrow}, 200'd2);
        chk("first_col", {184'b0, wcol}, 200'd2);
      end
      if (idx == 35) chk("k5_none_before_36", {199'b0, wv_k5}, 200'd0);
      if (idx == 36) begin
        chk("k5_first_valid", {199'b0, wv_k5}, 200'd1);
        chk("k5_first_out", wo_k5, mkwin(5, 4, 4, 0));
        chk("k5_top_left", {192'b0, wo_k5[199:192]}, 200'd0);
        chk("k5_bottom_right", {192'b0, wo_k5[7:0]}, 200'd36);
      end
      if (idx == 62) chk("fdone_early", {199'b0, fd}, 200'd0);
      if (idx == 63) begin
        chk("fdone_pulse", {199'b0, fd}, 200'd1);
        chk("fdone_s2", {199'b0, fd_s2}, 200'd1);
        chk("fdone_k5", {199'b0, fd_k5}, 200'd1);
        chk("last_out", {128'b0, wo}, mkwin(3, 7, 7, 0));
      end
    end
    @(posedge clk); #1;
    chk("fdone_one_cycle", {199'b0, fd}, 200'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("win_count_k3", 200'(cnt_m - m0), 200'd36);
    chk("win_count_s2", 200'(cnt_s2), 200'd9);
    chk("s2_last_row", 200'(last_s2_row), 200'd6);
    chk("s2_last_col", 200'(last_s2_col), 200'd6);
    chk("s2_last_br", 200'(last_s2_br), 200'd54);
    chk("win_count_k5", 200'(cnt_k5), 200'd16);
    chk("fdone_count", 200'(fd_cnt - f0), 200'd1);

    // Frame 2: backpressure after the first window.
    for (int idx = 0; idx < 19; idx++) push(idx, idx == 0, 1'b0);
    chk("bp_first_valid", {199'b0, wv}, 200'd1);
    wr = 1'b0;
    pin = 8'd19; pv = 1'b1;
    #1;
    chk("bp_ready_low", {199'b0, pr}, 200'd0);
    held_bad = 0;
    for (int n = 0; n < 10; n++) begin
      @(posedge clk); #1;
      if (wo !== 72'(mkwin(3, 2, 2, 0)) || !wv || pr) held_bad++;
    end
    chk("bp_held", 200'(held_bad), 200'd0);
    chk("bp_held_row", {184'b0, wrow}, 200'd2);
    wr = 1'b1;
    @(posedge clk); #1;
    pv = 1'b0;
    chk("bp_next_valid", {199'b0, wv}, 200'd1);
    chk("bp_next_out", {128'b0, wo}, mkwin(3, 2, 3, 0));
    chk("bp_next_col", {184'b0, wcol}, 200'd3);
    for (int idx = 20; idx < 64; idx++) push(idx, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;

    // Frame 3: sof restarts mid-frame; frame B values are 100+index.
    for (int idx = 0; idx < 30; idx++) push(idx, idx == 0, 1'b0);
    early = 0;
    for (int idx = 0; idx < 64; idx++) begin
      push(100 + idx, idx == 0, 1'b0);
      if (idx < 18 && wv) early++;
      if (idx == 18) begin
        chk("sof_first_valid", {199'b0, wv}, 200'd1);
        chk("sof_first_out", {128'b0, wo}, mkwin(3, 2, 2, 100));
        chk("sof_br", {192'b0, wo[7:0]}, 200'd118);
      end
    end
    chk("sof_no_early_win", 200'(early), 200'd0);
    repeat (2) @(posedge clk);
    #1;

    // Frame 4: reset mid-frame, then a full frame without sof.
    for (int idx = 0; idx < 21; idx++) push(idx, idx == 0, 1'b0);
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", {199'b0, wv}, 200'd0);
    chk("mid_rst_out", {128'b0, wo}, 200'd0);
    chk("mid_rst_row", {184'b0, wrow}, 200'd0);
    chk("mid_rst_col", {184'b0, wcol}, 200'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    m0 = cnt_m;
    for (int idx = 0; idx < 64; idx++) begin
      push(idx, 1'b0, 1'b0);
      if (idx == 17) chk("rst_no_win_17", {199'b0, wv}, 200'd0);
      if (idx == 18) begin
        chk("rst_first_out", {128'b0, wo}, mkwin(3, 2, 2, 0));
        chk("rst_first_row", {184'b0, wrow}, 200'd2);
      end
    end
    repeat (2) @(posedge clk);
    #1;
    chk("rst_win_count", 200'(cnt_m - m0), 200'd36);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
